// File: rtl/audio_sample_feeder_pkg.sv
// rtl/audio_sample_feeder_pkg.sv - shared types and constants for the audio sample feeder
//
// Purpose: feeder FSM state enum, DAC sample width and underrun counter width.
// Ports: none (package).

package audio_sample_feeder_pkg;

  // Feeder FSM: FILL primes the FIFO, RUN streams samples to the audio controller.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } feeder_state_e;

  localparam int SAMPLE_W   = 32;
  localparam int UNDERRUN_W = 16;

  localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = '1;

endpackage

// File: rtl/audio_sample_feeder_fifo.sv
// rtl/audio_sample_feeder_fifo.sv - show-ahead sample FIFO with occupancy count
//
// Purpose: DEPTH x W circular buffer. The head entry is visible on head_o
//          whenever the FIFO is non-empty, so a pop consumes it in the same cycle.
// Ports:
//   clk_i      clock, rising edge
//   resetn_i   synchronous active-low reset (clears pointers and count)
//   push_i     write wdata_i (ignored when full)
//   pop_i      drop the head entry (ignored when empty)
//   wdata_i    sample to store
//   head_o     oldest stored sample
//   count_o    occupancy, 0..DEPTH
//   full_o     count_o == DEPTH
//   empty_o    count_o == 0

module sample_fifo
  import audio_sample_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 7
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    full_o  = (count_q == CW'(DEPTH));
    empty_o = (count_q == '0);
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && !empty_o;

    // DEPTH is a power of two, so the natural AW-bit overflow is the wrap.
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end

    head_o  = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: resetting the pointers and count discards contents.
  always_ff @(posedge clk_i) begin
    if (resetn_i && push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/audio_sample_feeder.sv
// rtl/audio_sample_feeder.sv - buffers synth samples and feeds the audio DAC controller
//
// Purpose: FIFO-buffered bridge from an unsigned synth sample stream to the
//          32-bit signed stereo audio controller interface, with volume
//          attenuation, mute and underrun counting.
// Ports:
//   CLOCK_50                single clock, rising edge
//   resetn                  synchronous active-low reset
//   sample_in/_valid        offset-binary synth sample and its valid
//   sample_ready            FIFO has room this cycle
//   volume                  arithmetic right shift 0..15 applied on output
//   mute                    force output sample to zero
//   audio_out_allowed       audio controller has DAC FIFO space
//   write_audio_out         one-cycle write strobe to the audio controller
//   left/right_channel_audio_out  signed 32-bit sample (both identical)
//   fill_level              FIFO occupancy
//   underrun_count          saturating underrun event count

module audio_sample_feeder
  import audio_sample_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IN_W  = 7
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic [IN_W-1:0]        sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic [3:0]             volume,
  input  logic                   mute,
  input  logic                   audio_out_allowed,
  output logic                   write_audio_out,
  output logic [SAMPLE_W-1:0]    left_channel_audio_out,
  output logic [SAMPLE_W-1:0]    right_channel_audio_out,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [UNDERRUN_W-1:0]  underrun_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  feeder_state_e          state_q, state_d;
  logic [SAMPLE_W-1:0]    held_q, held_d;
  logic [UNDERRUN_W-1:0]  urun_q, urun_d;

  logic [IN_W-1:0]        head;
  logic [CW-1:0]          count;
  logic                   full, empty;
  logic                   push, pop, underrun;

  logic [IN_W-1:0]            centered;
  logic signed [SAMPLE_W-1:0] placed;
  logic signed [SAMPLE_W-1:0] shifted;
  logic [SAMPLE_W-1:0]        converted;
  logic [SAMPLE_W-1:0]        sample_out;

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (IN_W)
  ) u_fifo (
    .clk_i    (CLOCK_50),
    .resetn_i (resetn),
    .push_i   (push),
    .pop_i    (pop),
    .wdata_i  (sample_in),
    .head_o   (head),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

  always_comb begin
    // Offset-binary to two's complement: flip the MSB, then left-justify.
    centered  = {~head[IN_W-1], head[IN_W-2:0]};
    placed    = {centered, {(SAMPLE_W-IN_W){1'b0}}};
    shifted   = placed >>> volume;
    converted = mute ? '0 : shifted;
  end

  always_comb begin
    sample_ready = resetn && !full;
    push         = sample_valid && sample_ready;

    // Strobe follows allowed with no latency in RUN; reset masks it immediately.
    write_audio_out = resetn && (state_q == RUN) && audio_out_allowed;
    pop             = write_audio_out && !empty;
    underrun        = write_audio_out && empty;

    held_d = pop ? converted : held_q;
    urun_d = (underrun && (urun_q != UNDERRUN_MAX)) ? urun_q + UNDERRUN_W'(1) : urun_q;

    state_d = state_q;
    case (state_q)
      FILL:    if (count >= CW'(DEPTH / 2)) state_d = RUN;
      RUN:     if (underrun)                state_d = FILL;
      default: state_d = FILL;
    endcase

    // A pop shows the fresh conversion this cycle; otherwise (idle or
    // underrun) the last written sample is repeated.
    sample_out = !resetn ? '0 : (pop ? converted : held_q);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= FILL;
      held_q  <= '0;
      urun_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      urun_q  <= urun_d;
    end
  end

  assign left_channel_audio_out  = sample_out;
  assign right_channel_audio_out = sample_out;
  assign fill_level              = count;
  assign underrun_count          = urun_q;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb/tb_audio_sample_feeder.sv - directed self-checking bench for audio_sample_feeder

module tb_audio_sample_feeder;

  logic        CLOCK_50;
  logic        resetn;
  logic [6:0]  sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  volume;
  logic        mute;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic [3:0]  fill_level;
  logic [15:0] underrun_count;

  int n_checks = 0;
  int n_fails  = 0;

  audio_sample_feeder #(
    .DEPTH (8),
    .IN_W  (7)
  ) dut (
    .CLOCK_50                (CLOCK_50),
    .resetn                  (resetn),
    .sample_in               (sample_in),
    .sample_valid            (sample_valid),
    .sample_ready            (sample_ready),
    .volume                  (volume),
    .mute                    (mute),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .fill_level              (fill_level),
    .underrun_count          (underrun_count)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp);
    check({tag, "_left"}, left_channel_audio_out, exp);
    check({tag, "_right"}, right_channel_audio_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn            = 1'b0;
    sample_in         = '0;
    sample_valid      = 1'b0;
    volume            = '0;
    mute              = 1'b0;
    audio_out_allowed = 1'b1;

    // Reset state
    step();
    step();
    #1;
    check("rst_write", 32'(write_audio_out), 32'd0);
    check_out("rst", 32'h0);
    check("rst_ready", 32'(sample_ready), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_urun", 32'(underrun_count), 32'd0);

    // Prime with five samples; RUN starts the cycle after fill_level reaches 4
    resetn = 1'b1; sample_valid = 1'b1; sample_in = 7'h7F;
    #1;
    check("fill_ready", 32'(sample_ready), 32'd1);
    check("fill_write0", 32'(write_audio_out), 32'd0);
    step(); sample_in = 7'h00; #1; check("fill_lvl1", 32'(fill_level), 32'd1);
    step(); sample_in = 7'h40; #1; check("fill_lvl2", 32'(fill_level), 32'd2);
    step(); sample_in = 7'h00; #1; check("fill_lvl3", 32'(fill_level), 32'd3);
    step(); sample_in = 7'h00; #1;
    check("fill_lvl4", 32'(fill_level), 32'd4);
    check("fill_write_at4", 32'(write_audio_out), 32'd0);

    step(); sample_valid = 1'b0; #1;
    check("run_write", 32'(write_audio_out), 32'd1);
    check_out("conv_7f", 32'h7E000000);
    check("run_lvl5", 32'(fill_level), 32'd5);
    step(); #1; check_out("conv_00", 32'h80000000);
    step(); #1; check_out("conv_40", 32'h00000000);
    step(); mute = 1'b1; #1; check_out("conv_mute", 32'h00000000);
    step(); mute = 1'b0; volume = 4'd4; #1; check_out("conv_vol4", 32'hF8000000);
    check("pre_urun_lvl", 32'(fill_level), 32'd1);

    // Underrun: repeat held sample, count it, fall back to FILL
    step(); volume = 4'd0; #1;
    check("urun_lvl0", 32'(fill_level), 32'd0);
    check("urun_write", 32'(write_audio_out), 32'd1);
    check_out("urun_hold", 32'hF8000000);
    step(); #1;
    check("urun_cnt1", 32'(underrun_count), 32'd1);
    check("urun_fill_write", 32'(write_audio_out), 32'd0);
    check_out("idle_hold", 32'hF8000000);

    // Fill to full with no pops; a ninth valid sample must be dropped
    audio_out_allowed = 1'b0; sample_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample_in = 7'(7'h41 + i);
      step();
    end
    sample_in = 7'h11; #1;
    check("full_ready", 32'(sample_ready), 32'd0);
    check("full_lvl", 32'(fill_level), 32'd8);
    check("full_write", 32'(write_audio_out), 32'd0);
    step(); sample_valid = 1'b0; #1;
    check("full_lvl_after9", 32'(fill_level), 32'd8);

    // Drain in order; the dropped sample must not appear
    audio_out_allowed = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      e = 32'(i + 1) << 25;
      #1;
      check("drain_left", left_channel_audio_out, e);
      check("drain_lvl", 32'(fill_level), 32'(8 - i));
      step();
    end

    // Underrun coinciding with a push
    sample_valid = 1'b1; sample_in = 7'h7F; #1;
    check("urun2_write", 32'(write_audio_out), 32'd1);
    check_out("urun2_hold", 32'h10000000);
    step(); sample_valid = 1'b0; #1;
    check("urun2_cnt", 32'(underrun_count), 32'd2);
    check("urun2_lvl", 32'(fill_level), 32'd1);
    check("urun2_write_off", 32'(write_audio_out), 32'd0);

    // Mid-stream reset at fill_level 5
    audio_out_allowed = 1'b0; sample_valid = 1'b1; sample_in = 7'h50;
    repeat (4) step();
    sample_valid = 1'b0; #1;
    check("mid_lvl5", 32'(fill_level), 32'd5);
    resetn = 1'b0; audio_out_allowed = 1'b1; #1;
    check("mid_rst_write", 32'(write_audio_out), 32'd0);
    check_out("mid_rst", 32'h0);
    check("mid_rst_ready", 32'(sample_ready), 32'd0);
    step(); #1;
    check("post_rst_lvl", 32'(fill_level), 32'd0);
    check("post_rst_urun", 32'(underrun_count), 32'd0);
    check("post_rst_write", 32'(write_audio_out), 32'd0);
    resetn = 1'b1; #1;
    check("post_rel_write", 32'(write_audio_out), 32'd0);
    check_out("post_rel", 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
